// File: rtl/mem_master_pkg.sv
// Shared types and helpers for the halfword SRAM initiator.
package mem_master_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        CAP,
        RESP
    } state_e;

    // Size 2'b11 is never legal; halfwords need an even address, words a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_master.sv
// Byte/halfword/word initiator for a 16-bit big-endian halfword SRAM with one-cycle read.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 2**12,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic                  mem_rd_en_o,
    output logic [0:1]            mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [0:1][7:0]       mem_din_o,
    input  logic [0:1][7:0]       mem_dout_i
);

    localparam logic [ADDR_WIDTH-1:0] AddrTwo = ADDR_WIDTH'(2);

    state_e                state_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  mem_en_q;
    logic                  mem_rd_en_q;
    logic [0:1]            mem_wr_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [0:1][7:0]       mem_din_q;

    // Request FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 2'b00;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            // Memory bus and response are idle unless a state below drives them.
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 2'b00;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (req_we_i) begin
                            rdata_q <= '0;
                        end
                        if (misaligned(req_size_i, req_addr_i[1:0])) begin
                            rdata_q     <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            mem_en_q    <= 1'b1;
                            mem_rd_en_q <= !req_we_i;
                            mem_addr_q  <= req_addr_i;
                            if (req_we_i) begin
                                if (req_size_i == SZ_BYTE) begin
                                    mem_wr_en_q <= req_addr_i[0] ? 2'b01 : 2'b10;
                                    mem_din_q   <= {req_wdata_i[7:0], req_wdata_i[7:0]};
                                end else if (req_size_i == SZ_HALF) begin
                                    mem_wr_en_q <= 2'b11;
                                    mem_din_q   <= req_wdata_i[15:0];
                                end else begin
                                    mem_wr_en_q <= 2'b11;
                                    mem_din_q   <= req_wdata_i[31:16];
                                end
                            end
                            state_q <= ACC0;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ACC0: begin
                    if (size_q == SZ_WORD) begin
                        mem_en_q    <= 1'b1;
                        mem_rd_en_q <= !we_q;
                        mem_addr_q  <= addr_q + AddrTwo;
                        if (we_q) begin
                            mem_wr_en_q <= 2'b11;
                            mem_din_q   <= wdata_q[15:0];
                        end
                        state_q <= ACC1;
                    end else if (!we_q) begin
                        state_q <= CAP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                ACC1: begin
                    if (!we_q) begin
                        // Upper halfword read in ACC0 is on the bus now.
                        rdata_q[31:16] <= mem_dout_i;
                        state_q        <= CAP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                CAP: begin
                    if (size_q == SZ_BYTE) begin
                        rdata_q <= {24'b0, addr_q[0] ? mem_dout_i[1] : mem_dout_i[0]};
                    end else if (size_q == SZ_HALF) begin
                        rdata_q <= {16'b0, mem_dout_i};
                    end else begin
                        rdata_q[15:0] <= mem_dout_i;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_en_o    = mem_en_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural halfword SRAM attached.
module tb_mem_master;

    localparam int unsigned MemDepth = 4096;
    localparam int unsigned AW = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'b00;
    logic [AW-1:0]   req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic            req_ready_o;
    logic            rsp_valid_o;
    logic [31:0]     rsp_rdata_o;
    logic            rsp_err_o;
    logic            mem_en_o;
    logic            mem_rd_en_o;
    logic [0:1]      mem_wr_en_o;
    logic [AW-1:0]   mem_addr_o;
    logic [0:1][7:0] mem_din_o;
    logic [0:1][7:0] mem_dout;

    int total = 0;
    int bad = 0;

    mem_master #(.MEM_DEPTH(MemDepth)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .mem_en_o    (mem_en_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_din_o   (mem_din_o),
        .mem_dout_i  (mem_dout)
    );

    always #5 clk = ~clk;

    // Halfword SRAM: lane 0 is bits [15:8], registered read of the pre-write contents.
    logic [15:0] mem [MemDepth];
    initial begin
        for (int i = 0; i < int'(MemDepth); i++) mem[i] = 16'h0000;
        mem_dout = '0;
    end
    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_dout <= mem[mem_addr_o[AW-1:1]];
            if (mem_wr_en_o[0]) mem[mem_addr_o[AW-1:1]][15:8] <= mem_din_o[0];
            if (mem_wr_en_o[1]) mem[mem_addr_o[AW-1:1]][7:0] <= mem_din_o[1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_en_o, mem_rd_en_o,
                 mem_wr_en_o, mem_addr_o, mem_din_o};
    endfunction

    // Per-cycle trace of the memory bus after a handshake, index 1 = first cycle.
    logic          tr_en   [16];
    logic          tr_rd   [16];
    logic [1:0]    tr_wr   [16];
    logic [AW-1:0] tr_addr [16];
    logic [15:0]   tr_din  [16];

    task automatic run_req(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int acc, output logic idle_bus);
        int guard;
        guard = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        acc = 0;
        while (!rsp_valid_o && lat < 12) begin
            tr_en[lat]   = mem_en_o;
            tr_rd[lat]   = mem_rd_en_o;
            tr_wr[lat]   = mem_wr_en_o;
            tr_addr[lat] = mem_addr_o;
            tr_din[lat]  = mem_din_o;
            if (mem_en_o) acc++;
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata_o;
        er = rsp_err_o;
        idle_bus = |{mem_en_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_din_o};
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid_o), 32'd0);
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    sz;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        int            lat;
        logic          err;
        logic [31:0]   rd;
        int            acc;
        logic [1:0]    wr0;
        logic [15:0]   din0;
        logic [15:0]   din1;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int lat, acc;
        logic [31:0] rd;
        logic er, idle_bus;

        vecs[0]  = '{1'b1, 2'b01, 13'h0010, 32'h0000BEEF, 2, 1'b0, 32'h0, 1, 2'b11, 16'hBEEF, 16'h0};
        vecs[1]  = '{1'b0, 2'b01, 13'h0010, 32'h0, 3, 1'b0, 32'h0000BEEF, 1, 2'b00, 16'h0, 16'h0};
        vecs[2]  = '{1'b1, 2'b01, 13'h0020, 32'h0000AAAA, 2, 1'b0, 32'h0, 1, 2'b11, 16'hAAAA, 16'h0};
        vecs[3]  = '{1'b1, 2'b00, 13'h0021, 32'h00000011, 2, 1'b0, 32'h0, 1, 2'b01, 16'h1111, 16'h0};
        vecs[4]  = '{1'b0, 2'b01, 13'h0020, 32'h0, 3, 1'b0, 32'h0000AA11, 1, 2'b00, 16'h0, 16'h0};
        vecs[5]  = '{1'b0, 2'b00, 13'h0020, 32'h0, 3, 1'b0, 32'h000000AA, 1, 2'b00, 16'h0, 16'h0};
        vecs[6]  = '{1'b0, 2'b00, 13'h0021, 32'h0, 3, 1'b0, 32'h00000011, 1, 2'b00, 16'h0, 16'h0};
        vecs[7]  = '{1'b1, 2'b10, 13'h0100, 32'h12345678, 3, 1'b0, 32'h0, 2, 2'b11, 16'h1234,
                     16'h5678};
        vecs[8]  = '{1'b0, 2'b10, 13'h0100, 32'h0, 4, 1'b0, 32'h12345678, 2, 2'b00, 16'h0, 16'h0};
        vecs[9]  = '{1'b1, 2'b01, 13'h0003, 32'h0000FFFF, 1, 1'b1, 32'h0, 0, 2'b00, 16'h0, 16'h0};
        vecs[10] = '{1'b0, 2'b10, 13'h0102, 32'h0, 1, 1'b1, 32'h0, 0, 2'b00, 16'h0, 16'h0};
        vecs[11] = '{1'b0, 2'b11, 13'h0000, 32'h0, 1, 1'b1, 32'h0, 0, 2'b00, 16'h0, 16'h0};
        vecs[12] = '{1'b1, 2'b10, 13'h1FFC, 32'hCAFEF00D, 3, 1'b0, 32'h0, 2, 2'b11, 16'hCAFE,
                     16'hF00D};
        vecs[13] = '{1'b0, 2'b10, 13'h1FFC, 32'h0, 4, 1'b0, 32'hCAFEF00D, 2, 2'b00, 16'h0, 16'h0};
        vecs[14] = '{1'b1, 2'b00, 13'h0010, 32'h0000005A, 2, 1'b0, 32'h0, 1, 2'b10, 16'h5A5A, 16'h0};
        vecs[15] = '{1'b0, 2'b01, 13'h0010, 32'h0, 3, 1'b0, 32'h00005AEF, 1, 2'b00, 16'h0, 16'h0};

        // Reset release.
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wd, lat, rd, er, acc, idle_bus);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("v%0d_accesses", i), 32'(acc), 32'(vecs[i].acc));
            check($sformatf("v%0d_bus_idle_at_rsp", i), 32'(idle_bus), 32'd0);
            if (vecs[i].acc > 0 && lat > 1) begin
                check($sformatf("v%0d_acc0_addr", i), 32'(tr_addr[1]), 32'(vecs[i].addr));
                check($sformatf("v%0d_acc0_rd", i), 32'(tr_rd[1]), 32'(!vecs[i].we));
                check($sformatf("v%0d_acc0_wr", i), 32'(tr_wr[1]), 32'(vecs[i].wr0));
                check($sformatf("v%0d_acc0_din", i), 32'(tr_din[1]), 32'(vecs[i].din0));
            end
            if (vecs[i].acc == 2 && lat > 2) begin
                check($sformatf("v%0d_acc1_addr", i), 32'(tr_addr[2]), 32'(vecs[i].addr + 13'd2));
                check($sformatf("v%0d_acc1_wr", i), 32'(tr_wr[2]), 32'(vecs[i].wr0));
                check($sformatf("v%0d_acc1_din", i), 32'(tr_din[2]), 32'(vecs[i].din1));
            end
        end

        // Reset during the second halfword of a word write.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 13'h0100;
        req_wdata = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_acc0_en", 32'({mem_en_o, mem_addr_o}), 32'({1'b1, 13'h0100}));
        @(negedge clk);
        check("mid_acc1_en", 32'({mem_en_o, mem_addr_o}), 32'({1'b1, 13'h0102}));
        rst_n = 1'b0;
        #1;
        check("mid_reset_outs", 32'(any_out()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        run_req(1'b0, 2'b10, 13'h0100, 32'h0, lat, rd, er, acc, idle_bus);
        check("post_reset_latency", 32'(lat), 32'd4);
        check("post_reset_rdata", rd, 32'h9ABC5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
